// File: rtl/window_seq_ctrl_if.sv
// Handshake and sequencing bundle between the pixel source, the window/line-buffer
// datapath and the downstream MAC for window_seq_ctrl.
interface window_seq_ctrl_if #(
  parameter int CW = 5,
  parameter int RW = 5
);
  logic          start;
  logic          pix_valid;
  logic          pix_ready;
  logic          wr_sft_en;
  logic          lb_wr_en;
  logic [CW-1:0] lb_addr;
  logic          win_valid;
  logic          win_ready;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          busy;
  logic          done;

  // The controller side.
  modport slave (
    input  start, pix_valid, win_ready,
    output pix_ready, wr_sft_en, lb_wr_en, lb_addr,
           win_valid, win_row, win_col, busy, done
  );

  // The surrounding system side: pixel source, MAC and frame sequencer.
  modport master (
    output start, pix_valid, win_ready,
    input  pix_ready, wr_sft_en, lb_wr_en, lb_addr,
           win_valid, win_row, win_col, busy, done
  );
endinterface

// File: rtl/window_seq_ctrl.sv
// Raster-stream sequencer for the 3x3 window register and its two row line buffers.
// Optional macro STRIDE2_EN: only even-offset window positions raise win_valid.
module window_seq_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  window_seq_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic pix_ready;
  logic accept;
  logic qualify;
  logic last_col;
  logic last_pix;

  // A pending window that the MAC has not taken freezes the whole datapath.
  assign pix_ready = (state_q == STREAM) && !(win_valid_q && !bus.win_ready);
  assign accept    = pix_ready && bus.pix_valid;
  assign last_col  = (col_q == COL_LAST);
  assign last_pix  = last_col && (row_q == ROW_LAST);

`ifdef STRIDE2_EN
  // (x-2) even is the same as x even, so the LSBs carry the stride test.
  assign qualify = (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
`else
  assign qualify = (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          col_d   = '0;
          row_d   = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (last_pix) begin
            col_d   = '0;
            row_d   = '0;
            state_d = FLUSH;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      FLUSH: begin
        if (!win_valid_q || bus.win_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new qualifying pixel replaces a window consumed in the same cycle.
    if (accept && qualify) begin
      win_valid_d = 1'b1;
      win_row_d   = row_q;
      win_col_d   = col_q;
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.wr_sft_en = accept;
  assign bus.lb_wr_en  = accept;
  assign bus.lb_addr   = col_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
